// File: rtl/mem_copy_8bit.sv
// mem_copy_8bit: byte-serial block copy engine acting as the initiator on an
// 8-bit single-port RAM. On start it copies len bytes from src to dst (strictly
// forward, addresses wrap modulo 256) and then pulses done for one cycle.
// Every output is a register: the next-state logic computes the value each
// output must carry in the state being entered, and the flops present it for
// the whole of that state's cycle.
// RD_LAT selects the RAM read latency (0 = combinational read, 1 = registered).
// The file also holds mem_copy_8bit_checker, a protocol checker meant to be
// instantiated beside the engine in simulation.

module mem_copy_8bit #(
    parameter int RD_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // A registered-read RAM needs one extra cycle between address and data.
    localparam bit HAS_WAIT = (RD_LAT == 1);

    logic [2:0] state_r, state_s;
    logic [7:0] src_r, src_s;
    logic [7:0] dst_r, dst_s;
    logic [7:0] len_r, len_s;
    logic [7:0] idx_r, idx_s;
    logic [7:0] idx_inc_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       we_r, we_s;
    logic [7:0] addr_r, addr_s;
    logic [7:0] wdata_r, wdata_s;

    assign busy      = busy_r;
    assign done      = done_r;
    assign ram_we    = we_r;
    assign ram_addr  = addr_r;
    assign ram_wdata = wdata_r;

    // Index of the byte that follows the one just written; len <= 255 so the
    // index reaches len before it could wrap.
    always_comb begin
        idx_inc_s = idx_r + 8'd1;
    end

    // Next state plus the output values that belong to the state being entered.
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        dst_s   = dst_r;
        len_s   = len_r;
        idx_s   = idx_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        we_s    = 1'b0;
        addr_s  = 8'h00;
        wdata_s = wdata_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    src_s = src_addr;
                    dst_s = dst_addr;
                    len_s = len;
                    idx_s = 8'd0;
                    if (len != 8'd0) begin
                        state_s = ST_RD;
                        busy_s  = 1'b1;
                        addr_s  = src_addr;
                    end else begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RD: begin
                busy_s = 1'b1;
                if (HAS_WAIT) begin
                    // Keep the source address on the bus while the RAM registers it.
                    state_s = ST_WAIT;
                    addr_s  = src_r + idx_r;
                end else begin
                    // Read data is valid now; capture it as the write byte.
                    state_s = ST_WR;
                    we_s    = 1'b1;
                    addr_s  = dst_r + idx_r;
                    wdata_s = ram_rdata;
                end
            end

            ST_WAIT: begin
                state_s = ST_WR;
                busy_s  = 1'b1;
                we_s    = 1'b1;
                addr_s  = dst_r + idx_r;
                wdata_s = ram_rdata;
            end

            ST_WR: begin
                idx_s = idx_inc_s;
                if (idx_inc_s == len_r) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_RD;
                    busy_s  = 1'b1;
                    addr_s  = src_r + idx_inc_s;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                idx_s   = 8'd0;
            end
        endcase
    end

    // State, captured arguments and output registers; rst aborts a copy at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            src_r   <= 8'h00;
            dst_r   <= 8'h00;
            len_r   <= 8'h00;
            idx_r   <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            len_r   <= len_s;
            idx_r   <= idx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
        end
    end

endmodule

// Protocol checker for mem_copy_8bit: busy/done exclusivity, single-cycle
// write strobes and done pulses, and well-defined write address/data.
module mem_copy_8bit_checker #(
    parameter int RD_LAT = 0
) (
    input logic       clk,
    input logic       rst,
    input logic       busy,
    input logic       done,
    input logic       ram_we,
    input logic [7:0] ram_addr,
    input logic [7:0] ram_wdata
);

    a_rd_lat_legal: assert property (@(posedge clk) (RD_LAT == 0) || (RD_LAT == 1));

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy && done));

    a_we_single: assert property (@(posedge clk) disable iff (rst)
        ram_we |=> !ram_we);

    a_we_in_busy: assert property (@(posedge clk) disable iff (rst)
        ram_we |-> busy);

    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

    a_we_known: assert property (@(posedge clk) disable iff (rst)
        ram_we |-> !$isunknown({ram_addr, ram_wdata}));

endmodule

// File: tb/tb_mem_copy_8bit.sv
// Bench for mem_copy_8bit: two engines (combinational-read RAM and
// registered-read RAM), each with its own 256x8 RAM model. A reference memory
// image predicts every write, pushed to a queue at start and popped on each
// ram_we strobe; busy/done timing is checked every cycle.
module tb_mem_copy_8bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1;
    logic [7:0] src_addr, dst_addr, len;
    logic       busy0, done0, we0, busy1, done1, we1;
    logic [7:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] ref0 [256];
    logic [7:0] ref1 [256];
    logic [15:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    mem_copy_8bit #(.RD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy0), .done(done0), .ram_we(we0), .ram_addr(addr0),
        .ram_wdata(wdata0), .ram_rdata(rdata0)
    );

    mem_copy_8bit #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy1), .done(done1), .ram_we(we1), .ram_addr(addr1),
        .ram_wdata(wdata1), .ram_rdata(rdata1)
    );

    mem_copy_8bit_checker #(.RD_LAT(0)) chk0 (
        .clk(clk), .rst(rst), .busy(busy0), .done(done0),
        .ram_we(we0), .ram_addr(addr0), .ram_wdata(wdata0)
    );

    mem_copy_8bit_checker #(.RD_LAT(1)) chk1 (
        .clk(clk), .rst(rst), .busy(busy1), .done(done1),
        .ram_we(we1), .ram_addr(addr1), .ram_wdata(wdata1)
    );

    // RAM models: engine writes take priority over bench preload writes.
    always @(posedge clk) begin
        if (we0) mem0[addr0] <= wdata0;
        else if (pre_we) mem0[pre_addr] <= pre_data;
        if (we1) mem1[addr1] <= wdata1;
        else if (pre_we) mem1[pre_addr] <= pre_data;
        rdata1 <= mem1[addr1];
    end

    assign rdata0 = mem0[addr0];

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = v;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        ref0[a] = v;
        ref1[a] = v;
    endtask

    task automatic check_mem(input int lat, input string name);
        int diffs;
        int first;
        logic [7:0] got, want;
        diffs = 0;
        first = -1;
        for (int a = 0; a < 256; a++) begin
            got  = (lat == 1) ? mem1[a] : mem0[a];
            want = (lat == 1) ? ref1[a] : ref0[a];
            if (got !== want) begin
                diffs++;
                if (first < 0) first = a;
            end
        end
        n_cmp++;
        if (diffs !== 0) begin
            n_bad++;
            $display("FAIL mem_%s: %0d bytes differ, first at %02h", name, diffs, first);
        end
    endtask

    // Predicts the writes, runs one copy on the chosen engine and checks
    // busy/done every cycle plus each write against the queue.
    task automatic run_copy(input int lat, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] n, input bit extra_start, input string name);
        int total;
        logic [7:0] sa, da, v;
        logic b, dn, w;
        logic [7:0] a, wd;
        logic [15:0] e;
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            v  = (lat == 1) ? ref1[sa] : ref0[sa];
            if (lat == 1) ref1[da] = v;
            else ref0[da] = v;
            exp_q.push_back({da, v});
        end
        total = int'(n) * (2 + lat);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        if (lat == 1) start1 = 1'b1;
        else start0 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= total + 2; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            if (extra_start && c == 3) begin
                src_addr = 8'h00;
                dst_addr = 8'hC0;
                len      = 8'd7;
                if (lat == 1) start1 = 1'b1;
                else start0 = 1'b1;
            end
            b  = (lat == 1) ? busy1 : busy0;
            dn = (lat == 1) ? done1 : done0;
            w  = (lat == 1) ? we1 : we0;
            a  = (lat == 1) ? addr1 : addr0;
            wd = (lat == 1) ? wdata1 : wdata0;
            n_cmp++;
            if (b !== ((n != 8'd0) && (c <= total))) begin
                n_bad++;
                $display("FAIL %s_busy cyc=%0d got=%b exp=%b", name, c, b, (n != 8'd0) && (c <= total));
            end
            n_cmp++;
            if (dn !== (c == total + 1)) begin
                n_bad++;
                $display("FAIL %s_done cyc=%0d got=%b exp=%b", name, c, dn, c == total + 1);
            end
            if (w === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_extra_write cyc=%0d got addr=%02h data=%02h exp none", name, c, a, wd);
                end else begin
                    e = exp_q.pop_front();
                    if ({a, wd} !== e) begin
                        n_bad++;
                        $display("FAIL %s_write cyc=%0d got %02h:%02h exp %02h:%02h",
                                 name, c, a, wd, e[15:8], e[7:0]);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing_writes got %0d left exp 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        src_addr = 8'h12;
        dst_addr = 8'h34;
        len      = 8'd4;
        start0   = 1'b1;
        start1   = 1'b1;
        rst      = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy0, done0, we0, addr0, wdata0, busy1, done1, we1, addr1, wdata1} !== 38'd0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got b%b d%b w%b a%02h wd%02h exp all 0",
                         c, busy0, done0, we0, addr0, wdata0);
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
        rst    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy0, done0, we0, busy1, done1, we1} !== 6'd0) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got b%b d%b w%b exp 0", c, busy0, done0, we0);
            end
        end
        for (int a = 0; a < 256; a++) poke(8'(a), 8'h00);
    endtask

    task automatic test_basic_copy();
        poke(8'h10, 8'h11);
        poke(8'h11, 8'h22);
        poke(8'h12, 8'h33);
        poke(8'h13, 8'h44);
        run_copy(0, 8'h10, 8'h80, 8'd4, 1'b0, "basic0");
        check_mem(0, "basic0");
        n_cmp++;
        if ({mem0[8'h80], mem0[8'h83], mem0[8'h10]} !== 24'h114411) begin
            n_bad++;
            $display("FAIL basic0_bytes got %02h %02h %02h exp 11 44 11", mem0[8'h80], mem0[8'h83], mem0[8'h10]);
        end
        run_copy(1, 8'h10, 8'h80, 8'd4, 1'b0, "basic1");
        check_mem(1, "basic1");
    endtask

    task automatic test_wrap();
        poke(8'hFE, 8'hA1);
        poke(8'hFF, 8'hB2);
        poke(8'h00, 8'hC3);
        run_copy(0, 8'hFE, 8'h40, 8'd3, 1'b0, "wrap_src");
        check_mem(0, "wrap_src");
        n_cmp++;
        if ({mem0[8'h40], mem0[8'h41], mem0[8'h42]} !== 24'hA1B2C3) begin
            n_bad++;
            $display("FAIL wrap_bytes got %02h %02h %02h exp A1 B2 C3", mem0[8'h40], mem0[8'h41], mem0[8'h42]);
        end
        run_copy(0, 8'h40, 8'hFF, 8'd2, 1'b0, "wrap_dst");
        check_mem(0, "wrap_dst");
    endtask

    task automatic test_zero_len();
        run_copy(0, 8'h10, 8'h90, 8'd0, 1'b0, "len0");
        check_mem(0, "len0");
        run_copy(0, 8'h00, 8'h00, 8'd255, 1'b0, "len255");
        check_mem(0, "len255");
    endtask

    task automatic test_overlap();
        poke(8'h20, 8'hA5);
        poke(8'h21, 8'h01);
        poke(8'h22, 8'h02);
        poke(8'h23, 8'h03);
        run_copy(0, 8'h20, 8'h21, 8'd3, 1'b0, "overlap");
        check_mem(0, "overlap");
        n_cmp++;
        if ({mem0[8'h21], mem0[8'h22], mem0[8'h23]} !== 24'hA5A5A5) begin
            n_bad++;
            $display("FAIL overlap_bytes got %02h %02h %02h exp A5 A5 A5", mem0[8'h21], mem0[8'h22], mem0[8'h23]);
        end
    endtask

    task automatic test_start_while_busy();
        run_copy(0, 8'h10, 8'h90, 8'd4, 1'b1, "busy_start");
        check_mem(0, "busy_start");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy0, we0, done0} !== 3'b000) begin
                n_bad++;
                $display("FAIL busy_start_queued cyc=%0d got b%b w%b d%b exp 000", c, busy0, we0, done0);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        for (int a = 8'h80; a <= 8'h83; a++) poke(8'(a), 8'h00);
        @(negedge clk);
        src_addr = 8'h10;
        dst_addr = 8'h80;
        len      = 8'd4;
        start0   = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        n_cmp++;
        if ({busy0, we0, addr0} !== {1'b1, 1'b0, 8'h12}) begin
            n_bad++;
            $display("FAIL midrst_rd_byte2 got b%b w%b a%02h exp b1 w0 a12", busy0, we0, addr0);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy0, done0, we0, addr0, wdata0} !== 19'd0) begin
            n_bad++;
            $display("FAIL midrst_async got b%b d%b w%b a%02h wd%02h exp 0", busy0, done0, we0, addr0, wdata0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy0, done0, we0} !== 3'b000) begin
                n_bad++;
                $display("FAIL midrst_after cyc=%0d got b%b d%b w%b exp 000", c, busy0, done0, we0);
            end
        end
        ref0[8'h80] = 8'h11;
        ref0[8'h81] = 8'h22;
        check_mem(0, "midrst");
    endtask

    initial begin
        pre_we   = 1'b0;
        pre_addr = 8'h00;
        pre_data = 8'h00;
        test_reset();
        test_basic_copy();
        test_wrap();
        test_zero_len();
        test_overlap();
        test_start_while_busy();
        test_reset_mid_copy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
